bcd_mmss_timer: RTL
===================

BCD_MMSS_TIMER -- requirements
Module: bcd_mmss_timer

Interface
REQ-001 Parameter MIN_MAX, default 59, meaning the highest minute value shown; legal range 1..99.
REQ-002 Parameter DOWN_EN, default 1, meaning count-down mode is supported; when 0, dir is ignored and treated as 0.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 tick_1hz  in  1  one-clk-wide enable pulse that drives run counting.
REQ-006 tick_2hz  in  1  one-clk-wide enable pulse that drives adjust stepping.
REQ-007 pause  in  1  level; 1 freezes run counting.
REQ-008 adj  in  1  level; 1 selects adjust mode.
REQ-009 sel  in  1  adjust target: 1 = seconds field, 0 = minutes field.
REQ-010 dir  in  1  run direction: 0 = up, 1 = down.
REQ-011 sec_ones, sec_tens, min_ones, min_tens  out  4 each  BCD digits, registered.
REQ-012 wrap  out  1  one-clk pulse when an up-count rolls over MIN_MAX:59 to 00:00.
REQ-013 done  out  1  level; set when a down-count reaches 00:00.

Function
REQ-014 Priority order shall be: rst, then adj, then pause, then run.
REQ-015 Run mode (adj=0, pause=0, dir=0) shall add 1 second on each tick_1hz, with BCD carries: sec_ones 9->0 carries to sec_tens; sec 59->00 carries to minutes; min_ones 9->0 carries to min_tens.
REQ-016 Up-counting at MIN_MAX:59 shall go to 00:00 and pulse wrap high for exactly the cycle after the tick edge.
REQ-017 Run mode with dir=1 (DOWN_EN=1) shall subtract 1 second per tick_1hz with BCD borrows: sec 00->59 borrows from minutes; min_ones 0->9 borrows from min_tens.
REQ-018 Down-counting shall stop at 00:00: the tick that reaches 00:00 sets done, and later down ticks leave the value at 00:00 with done held at 1.
REQ-019 done shall clear on rst, on any adjust step, or on any up-count tick.
REQ-020 In adjust mode (adj=1), each tick_2hz shall add 1 to the selected field only, with no carry into the other field.
REQ-021 Adjust wraps: the seconds field goes 59->00; the minutes field goes MIN_MAX->00; wrap stays 0.
REQ-022 In adjust mode, tick_1hz, pause and dir shall be ignored; in run mode, tick_2hz shall be ignored.
REQ-023 With pause=1 and adj=0, all state shall hold, wrap=0 and done shall hold.
REQ-024 Ticks arriving on the same cycle: only the tick belonging to the current mode acts; there is never a double step.
REQ-025 Changing sel or adj between ticks shall not alter the digits; the change takes effect at the next relevant tick.
REQ-026 Each digit shall always be in the range 0..9, tens-of-seconds in 0..5, and minutes at most MIN_MAX.
REQ-027 Latency: digits update on the same rising edge that samples the tick; no added pipeline stages.

Reset
REQ-028 On rst=1 at a rising clk edge, all digits shall become 0, with wrap=0 and done=0.
REQ-029 rst shall override any tick, adjust or pause input on that same cycle.
REQ-030 The state after rst de-asserts shall be 00:00, idle, with no pending step.
REQ-031 A reset mid-count shall discard any partial carry or borrow.

Structure
REQ-032 A shared package shall hold the BCD digit type (4 bits), SEC_MAX=59, and the MIN_MAX legal-range limits.
REQ-033 One sub-module, bcd_mod_field, shall be instantiated twice (seconds and minutes).
REQ-034 bcd_mod_field shall be a two-digit BCD mod-(MAX+1) counter with inc, dec, carry_out, borrow_out and an is_zero flag.
REQ-035 The top level shall hold the mode arbitration, carry/borrow chaining, and the wrap and done registers.

Verification
REQ-036 Up-count: rst, then 3599 tick_1hz with MIN_MAX=59 -> 59:59; the next tick -> 00:00 with a single-cycle wrap=1.
REQ-037 Carry: preset 09:59 via adjust, then one up tick -> 10:00; 19:59 -> 20:00.
REQ-038 Down-count: preset 01:00, dir=1, 60 ticks -> 00:00 with done=1; 5 more ticks -> still 00:00, done=1; one up tick -> 00:01, done=0.
REQ-039 Adjust: adj=1, sel=0, 60 tick_2hz from 00:00 -> min 00, sec unchanged; sel=1, 61 ticks -> sec 01, minutes unchanged; tick_1hz pulses during adjust -> no effect.
REQ-040 Pause/simultaneous: pause=1 with 10 tick_1hz -> value unchanged; adj=0 with tick_1hz and tick_2hz in the same cycle -> exactly +1 second.
REQ-041 Reset priority: rst=1 on the same cycle as a tick at 59:59 -> 00:00, wrap=0, done=0; repeat with MIN_MAX=5 to confirm the minutes wrap is 05->00.

Source files
------------

// File: rtl/bcd_mmss_timer_pkg.sv
// rtl/bcd_mmss_timer_pkg.sv - shared BCD types and range limits for the mm:ss timer
package bcd_mmss_timer_pkg;
  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX_LO = 1;
  localparam int MIN_MAX_HI = 99;

  function automatic int clamp_min_max(input int v);
    if (v < MIN_MAX_LO) return MIN_MAX_LO;
    if (v > MIN_MAX_HI) return MIN_MAX_HI;
    return v;
  endfunction
endpackage

// File: rtl/bcd_mmss_timer_if.sv
// rtl/bcd_mmss_timer_if.sv - control inputs and BCD display outputs of the mm:ss timer
interface bcd_mmss_timer_if;
  import bcd_mmss_timer_pkg::*;

  logic tick_1hz;
  logic tick_2hz;
  logic pause;
  logic adj;
  logic sel;
  logic dir;
  bcd_t sec_ones;
  bcd_t sec_tens;
  bcd_t min_ones;
  bcd_t min_tens;
  logic wrap;
  logic done;

  modport master (
    output tick_1hz, tick_2hz, pause, adj, sel, dir,
    input  sec_ones, sec_tens, min_ones, min_tens, wrap, done
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause, adj, sel, dir,
    output sec_ones, sec_tens, min_ones, min_tens, wrap, done
  );
endinterface

// File: rtl/bcd_mmss_timer_bcd_mod_field.sv
// rtl/bcd_mmss_timer_bcd_mod_field.sv - two-digit BCD mod-(MAX+1) up/down counter
module bcd_mod_field
  import bcd_mmss_timer_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output bcd_t ones,
  output bcd_t tens,
  output logic carry_out,
  output logic borrow_out,
  output logic is_zero
);
  localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);
  localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);

  logic at_max;

  assign at_max     = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign is_zero    = (tens == 4'd0) && (ones == 4'd0);
  assign carry_out  = inc && at_max;
  // inc wins over dec, so a borrow is only reported when dec really acts
  assign borrow_out = dec && !inc && is_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        ones <= 4'd0;
        tens <= 4'd0;
      end else if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end else if (dec) begin
      if (is_zero) begin
        ones <= MAX_ONES;
        tens <= MAX_TENS;
      end else if (ones == 4'd0) begin
        ones <= 4'd9;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end
endmodule

// File: rtl/bcd_mmss_timer.sv
// rtl/bcd_mmss_timer.sv - BCD mm:ss run/adjust timer with wrap and done flags
module bcd_mmss_timer
  import bcd_mmss_timer_pkg::*;
#(
  parameter int MIN_MAX = 59,
  parameter int DOWN_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  bcd_mmss_timer_if.slave bus
);
  localparam int MIN_LIM = clamp_min_max(MIN_MAX);

  logic dir_eff, run_tick, up, down, adj_step;
  logic sec_inc, sec_dec, min_inc, min_dec;
  logic sec_carry, sec_borrow, sec_zero;
  logic min_carry, min_borrow, min_zero;
  logic all_zero, at_one;
  logic wrap_q, done_q;

  assign dir_eff  = (DOWN_EN != 0) && bus.dir;
  assign run_tick = !bus.adj && !bus.pause && bus.tick_1hz;
  assign up       = run_tick && !dir_eff;
  assign down     = run_tick && dir_eff;
  assign adj_step = bus.adj && bus.tick_2hz;

  assign all_zero = sec_zero && min_zero;
  assign at_one   = min_zero && (bus.sec_tens == 4'd0) && (bus.sec_ones == 4'd1);

  // down-counting parks at 00:00 instead of borrowing into MIN_MAX:59
  assign sec_inc = up || (adj_step && bus.sel);
  assign sec_dec = down && !all_zero;
  assign min_inc = (up && sec_carry) || (adj_step && !bus.sel);
  assign min_dec = down && !all_zero && sec_borrow;

  bcd_mod_field #(.MAX(SEC_MAX)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .inc        (sec_inc),
    .dec        (sec_dec),
    .ones       (bus.sec_ones),
    .tens       (bus.sec_tens),
    .carry_out  (sec_carry),
    .borrow_out (sec_borrow),
    .is_zero    (sec_zero)
  );

  bcd_mod_field #(.MAX(MIN_LIM)) u_min (
    .clk        (clk),
    .rst        (rst),
    .inc        (min_inc),
    .dec        (min_dec),
    .ones       (bus.min_ones),
    .tens       (bus.min_tens),
    .carry_out  (min_carry),
    .borrow_out (min_borrow),
    .is_zero    (min_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= up && min_carry;
      if (adj_step || up) begin
        done_q <= 1'b0;
      end else if (down && (all_zero || at_one)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign bus.wrap = wrap_q;
  assign bus.done = done_q;

  logic unused_borrow;
  assign unused_borrow = min_borrow;
endmodule
